// File: rtl/dmem_if.sv
// Request/response bundle between the MEM-stage pipeline and the data-memory responder.
// The pipeline is the master; the responder is the slave.
interface dmem_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        err;

    modport master (
        output mem_rd, mem_wr, addr, size, is_unsigned, wr_data,
        input  rd_data, stall, err
    );

    modport slave (
        input  mem_rd, mem_wr, addr, size, is_unsigned, wr_data,
        output rd_data, stall, err
    );
endinterface

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: byte/half/word loads and stores on a word RAM,
// with a fixed number of stall cycles per access and rejection of misaligned or conflicting requests.
module dmem_responder #(
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYC > 2) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   rd_data_r;
    logic [31:0]   mem_r [DEPTH];

    logic          req_s;
    logic          bad_s;
    logic          go_done_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   word_s;
    logic          unused_addr_s;

    // Select the addressed lane(s) of a RAM word and extend to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    // Merge store data into the old RAM word, preserving lanes outside the access.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] lane, input logic [1:0] sz);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b00:   r[{lane, 3'b000} +: 8]       = wd[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16]  = wd[15:0];
            default: r                            = wd;
        endcase
        return r;
    endfunction

    // Request decode, RAM addressing and the "access completes on this edge" strobe.
    always_comb begin
        req_s  = bus.mem_rd | bus.mem_wr;
        bad_s  = (bus.mem_rd & bus.mem_wr)
               | (bus.size == 2'b11)
               | ((bus.size == 2'b01) & bus.addr[0])
               | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));
        idx_s  = bus.addr[AW+1:2];
        word_s = mem_r[idx_s];
        case (state_r)
            IDLE:    go_done_s = req_s & ~bad_s & (WAIT_CYC == 32'sd1);
            BUSY:    go_done_s = (cnt_r == {CW{1'b0}});
            default: go_done_s = 1'b0;
        endcase
    end

    // Upper address bits wrap the RAM and are deliberately ignored.
    assign unused_addr_s = ^bus.addr[31:AW+2];

    // Stall and err are combinational on the request so the pipeline freezes in the request cycle.
    assign bus.stall   = ~reset & ((state_r == BUSY) | ((state_r == IDLE) & req_s & ~bad_s));
    assign bus.err     = ~reset & (state_r == IDLE) & req_s & bad_s;
    assign bus.rd_data = rd_data_r;

    // Access sequencing FSM with the registered load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            rd_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s & ~bad_s) begin
                        if (WAIT_CYC == 32'sd1) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= CW'(WAIT_CYC - 32'sd2);
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
            if (go_done_s & bus.mem_rd) begin
                rd_data_r <= load_ext(word_s, bus.addr[1:0], bus.size, bus.is_unsigned);
            end
        end
    end

    // RAM write on the completing edge; reset aborts the store and never clears contents.
    always_ff @(posedge clk) begin
        if (~reset & go_done_s & bus.mem_wr) begin
            mem_r[idx_s] <= store_merge(word_s, bus.wr_data, bus.addr[1:0], bus.size);
        end
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the MEM stage of the pipeline. It is the target end of the mem_rd / mem_wr request lines driven by the decode-stage control signals.
- Services byte, half and word loads and stores against an internal word-organised RAM, with a fixed number of wait states.
- Holds the pipeline through a stall output until each access completes.
- Flags misaligned or conflicting requests without performing them.

Parameters:
- DEPTH, 256, number of 32-bit words in RAM; power of two, at least 4
- WAIT_CYC, 2, stall cycles per access; at least 1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_rd  in  1  load request; held stable by pipeline while stall=1
- mem_wr  in  1  store request; held stable while stall=1
- addr  in  32  byte address
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- is_unsigned  in  1  zero-extend loads when 1, sign-extend when 0
- wr_data  in  32  store data; sub-word data taken from low bits
- rd_data  out  32  load result, registered
- stall  out  1  freeze upstream pipeline stages
- err  out  1  one-cycle pulse for a rejected request

Behaviour:
- Reset (sampled on clk edge with reset=1):
  - state=IDLE, cnt=0, rd_data=0, err=0.
  - stall reads 0 during the reset cycle.
  - RAM contents are not cleared.
  - Reset in BUSY aborts the access: no RAM write, rd_data is not updated.
- req = mem_rd | mem_wr.
- bad = (mem_rd & mem_wr) | (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=00).
- FSM states: IDLE, BUSY, DONE.
  - IDLE, req & bad: err=1 for this cycle, stall=0, stay IDLE. RAM and rd_data are untouched, so the request is consumed by the pipeline as a no-op.
  - IDLE, req & !bad: stall=1 (combinational). If WAIT_CYC==1, go to DONE; else cnt<=WAIT_CYC-2 and go to BUSY.
  - BUSY: stall=1. If cnt==0, go to DONE; else cnt<=cnt-1.
  - Transition into DONE (same edge):
    - A store writes the RAM.
    - A load updates rd_data.
    - Both use the request values held on the inputs.
  - DONE: stall=0 and rd_data is valid. The pipeline advances at the end of this cycle. Always go to IDLE; a request seen in DONE is the one just completed and is ignored.
- Timing:
  - A good request occupies WAIT_CYC+1 cycles: WAIT_CYC stalled cycles plus 1 DONE cycle.
  - Back-to-back requests start no earlier than the cycle after DONE.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
  - Byte lane = addr[1:0]; half lane = addr[1].
- Stores:
  - Byte: write only lane addr[1:0] with wr_data[7:0].
  - Half: write lanes 2*addr[1] and 2*addr[1]+1 with wr_data[15:0].
  - Word: write all 4 lanes.
  - Other lanes are preserved.
- Loads:
  - Select the lane(s), then extend to 32 bits (sign or zero, per is_unsigned).
  - is_unsigned is ignored for word loads.
- rd_data holds its value across stores, errors and idle cycles until the next completed load.
- mem_rd and mem_wr both high is treated as bad; no access is performed.

Test Plan:
- Word store/load, WAIT_CYC=2:
  - Stimulus: store 0xDEADBEEF to 0x10, then load word from 0x10.
  - Response: stall high for 2 cycles per access. rd_data=0xDEADBEEF in the load's DONE cycle. Each request spans 3 cycles.
- Sub-word stores:
  - Stimulus: store 0x11223344 to 0x20, then byte store 0xAA to 0x22, then half store 0x5566 to 0x20.
  - Response: word load of 0x20 returns 0x11AA5566.
- Load extension:
  - Byte load from 0x22: signed gives 0xFFFFFFAA; unsigned gives 0x000000AA.
  - Half load from 0x20 (0x5566): signed gives 0x00005566.
- Errors:
  - Half load from 0x21, word store to 0x22, or mem_rd=mem_wr=1.
  - Response: err pulses 1 cycle, stall stays 0, RAM and rd_data unchanged (checked by a subsequent load).
- Wrap-around, DEPTH=256:
  - Stimulus: store 0x12345678 to 0x400, then load from 0x000.
  - Response: 0x12345678.
- Reset mid-access:
  - Stimulus: assert reset in the BUSY cycle of a store of 0xCAFEF00D to 0x30 whose old value is 0x0.
  - Response: stall=0, rd_data=0 in the reset cycle, state IDLE. A later load of 0x30 returns 0x0.
